pchigh: RTL and testbench
=========================

# pchigh

Program-counter high byte (PCH) for the 6502 datapath. It sits directly downstream of the PCL stage and consumes that stage's carry-out `pclc`, so the two bytes together form one atomic 16-bit PC increment. It loads from the ADH address bus or the internal data bus, and drives its value onto ADH and DB under control-unit enables. It also raises single-cycle status pulses on page advance and on 0xFFFF→0x0000 wrap for the sequencer.

## Interface
- `WIDTH`, default 8: register width; only 8 is supported.
- `RSTVAL`, default 8'h00: PCH value loaded on reset.

- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `adhin`  in  8: ADH bus input.
- `adhwa`  in  1: load PCH from `adhin`.
- `dbin`  in  8: internal data bus input.
- `dbwa`  in  1: load PCH from `dbin`.
- `pclc`  in  1: carry from PCL; increment PCH this edge.
- `adhoa`  in  1: drive PCH onto `adhout`.
- `dboa`  in  1: drive PCH onto `dbout`.
- `adhout`  out  8: PCH when `adhoa`=1, else 8'hzz.
- `dbout`  out  8: PCH when `dboa`=1, else 8'hzz.
- `pagex`  out  1: registered; 1 for one cycle after a carry-driven increment.
- `pcwrap`  out  1: registered; 1 for one cycle after a carry increment from 8'hFF to 8'h00.

## Operation
- One 8-bit register `pch`, plus registered flags `pagex` and `pcwrap`.
- Next-state priority, evaluated on each rising `clk`:
  1. `adhwa`=1: `pch`←`adhin`.
  2. Else `dbwa`=1: `pch`←`dbin`.
  3. Else `pclc`=1: `pch`←`pch`+1, modulo 256.
  4. Else: hold.
- A load always overrides a simultaneous `pclc`. The carry is discarded, not deferred.
- `pagex` next value: 1 only when branch 3 is taken, else 0.
- `pcwrap` next value: 1 only when branch 3 is taken and `pch` was 8'hFF, else 0.
- Output drivers are combinational from the current `pch`:
  - `adhout` and `dbout` are independent; both may be driven at once.
  - Each output is 8'hzz when its enable is 0.
  - A value loaded on an edge is visible on the enabled output in that same clock period, after the edge.
- Reset, asserted at any time, including mid-increment:
  - `pch`←`RSTVAL`, `pagex`←0, `pcwrap`←0 immediately, without waiting for `clk`.
  - Outputs still obey their enables during reset.
- No other state exists; there is no FSM beyond the priority mux.

## Timing
- `pclc` is combinational from PCL (PCL is at 8'hFF with its `inc` asserted).
- PCH samples `pclc` on the same edge PCL wraps to 8'h00, so the 16-bit PC advances in exactly one cycle with no extra latency.
- Load latency is one edge from enable to register.
- Flag latency:
  - `pagex` and `pcwrap` rise on the edge that performs the increment.
  - They fall on the next edge unless another increment occurs on that edge.
  - Back-to-back `pclc` cycles hold `pagex` high continuously.
- Reset release: the first update occurs on the first rising `clk` after `rst` falls.
- Input setup requirement: `adhwa`, `dbwa`, `pclc`, `adhin` and `dbin` are stable before the rising edge. No internal synchronisation is performed.

## Structure
- Shared package `pc_pkg` holds:
  - `PC_W` = 8.
  - `BUS_Z` = 8'hzz.
  - The 16-bit PC vector reset constant, whose upper byte supplies `RSTVAL`. PCL uses the same package.
- One sub-module is natural: `busdrv`, an 8-bit tri-state driver (input, enable, output). Instantiate it twice, for ADH and DB. PCL reuses it.
- Keep the register, priority mux and flag logic in the top level.

## Test plan
- Reset then readback: pulse `rst`; `adhoa`=1 → `adhout`=8'h00; `dbout`=8'hzz; `pagex`=`pcwrap`=0.
- ADH load with dual drive: `adhin`=8'h3C, `adhwa`=1 for one edge; set `adhoa`=`dboa`=1 → both outputs 8'h3C.
  - Clear the enables → both outputs 8'hzz.
- Carry chain with PCL: start PC=0x12FF, PCL `inc`=1 for one cycle.
  - → PCL=8'h00 and PCH=8'h13 on the same edge.
  - → `pagex`=1 for exactly one cycle, `pcwrap`=0.
- Wrap: load PCH 8'hFF via `dbin`/`dbwa`, assert `pclc` one cycle.
  - → PCH=8'h00, `pagex`=1 and `pcwrap`=1 for one cycle.
- Simultaneous events: `adhwa`=1 with `adhin`=8'h80, `dbwa`=1 with `dbin`=8'h40, and `pclc`=1, all on one edge.
  - → PCH=8'h80, `pagex`=0.
- Async reset mid-operation: PCH=8'h55 with `pclc` toggling; assert `rst` between edges.
  - → PCH=8'h00 before the next edge.
  - After release, the first `pclc` edge → PCH=8'h01.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared program-counter definitions used by both the PCL and PCH byte stages.
package pc_pkg;

    localparam int unsigned PC_W = 8;

    localparam logic [PC_W-1:0] BUS_Z = 8'hzz;

    // Full 16-bit PC value after reset; PCH takes the upper byte, PCL the lower.
    localparam logic [15:0] PC_RST = 16'h0000;

    function automatic logic [PC_W-1:0] pc_rst_hi();
        return PC_RST[15:8];
    endfunction

endpackage

// File: rtl/busdrv.sv
// 8-bit tri-state bus driver; floats its output whenever the enable is low.
module busdrv
    import pc_pkg::*;
(
    input  logic [PC_W-1:0] din,
    input  logic            en,
    output logic [PC_W-1:0] dout
);

    assign dout = en ? din : BUS_Z;

endmodule

// File: rtl/pchigh.sv
// Program-counter high byte: loadable from ADH or DB, increments on the PCL carry,
// and flags page advance / full 16-bit wrap for one cycle.
module pchigh
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH  = PC_W,
    parameter logic [WIDTH-1:0] RSTVAL = pc_rst_hi()
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] adhin,
    input  logic             adhwa,
    input  logic [WIDTH-1:0] dbin,
    input  logic             dbwa,
    input  logic             pclc,
    input  logic             adhoa,
    input  logic             dboa,
    output logic [WIDTH-1:0] adhout,
    output logic [WIDTH-1:0] dbout,
    output logic             pagex,
    output logic             pcwrap
);

    logic [WIDTH-1:0] pch_q, pch_d;
    logic             pagex_q, pagex_d;
    logic             pcwrap_q, pcwrap_d;

    // Loads win over the carry; a carry coinciding with a load is dropped.
    always_comb begin
        pch_d    = pch_q;
        pagex_d  = 1'b0;
        pcwrap_d = 1'b0;
        if (adhwa) begin
            pch_d = adhin;
        end else if (dbwa) begin
            pch_d = dbin;
        end else if (pclc) begin
            pch_d    = pch_q + WIDTH'(1);
            pagex_d  = 1'b1;
            pcwrap_d = &pch_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pch_q    <= RSTVAL;
            pagex_q  <= 1'b0;
            pcwrap_q <= 1'b0;
        end else begin
            pch_q    <= pch_d;
            pagex_q  <= pagex_d;
            pcwrap_q <= pcwrap_d;
        end
    end

    assign pagex  = pagex_q;
    assign pcwrap = pcwrap_q;

    busdrv u_adhdrv (
        .din  (pch_q),
        .en   (adhoa),
        .dout (adhout)
    );

    busdrv u_dbdrv (
        .din  (pch_q),
        .en   (dboa),
        .dout (dbout)
    );

endmodule

// File: tb/tb_pchigh.sv
// Self-checking bench for pchigh: directed scenarios plus randomized traffic
// against a behavioural model of the PCH byte.
module tb_pchigh;
    import pc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] adhin, dbin;
    logic       adhwa, dbwa, pclc, adhoa, dboa;
    wire  [7:0] adhout, dbout;
    logic       pagex, pcwrap;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pch;
    int m_pcl;
    bit m_pagex, m_pcwrap;

    pchigh dut (
        .clk    (clk),
        .rst    (rst),
        .adhin  (adhin),
        .adhwa  (adhwa),
        .dbin   (dbin),
        .dbwa   (dbwa),
        .pclc   (pclc),
        .adhoa  (adhoa),
        .dboa   (dboa),
        .adhout (adhout),
        .dbout  (dbout),
        .pagex  (pagex),
        .pcwrap (pcwrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] v;
        v = 8'(m_pch);
        check({tag, ":adhout"}, adhout, adhoa ? v : BUS_Z);
        check({tag, ":dbout"}, dbout, dboa ? v : BUS_Z);
        check({tag, ":pagex"}, {7'd0, pagex}, {7'd0, m_pagex});
        check({tag, ":pcwrap"}, {7'd0, pcwrap}, {7'd0, m_pcwrap});
    endtask

    task automatic idle();
        adhwa = 1'b0;
        dbwa  = 1'b0;
        pclc  = 1'b0;
    endtask

    // One rising edge; model follows the load/load/carry/hold priority rule.
    task automatic step();
        @(posedge clk);
        m_pagex  = 1'b0;
        m_pcwrap = 1'b0;
        if (adhwa) begin
            m_pch = int'(adhin);
        end else if (dbwa) begin
            m_pch = int'(dbin);
        end else if (pclc) begin
            m_pagex  = 1'b1;
            m_pcwrap = (m_pch == 255);
            m_pch    = (m_pch + 1) % 256;
        end
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        adhin = 8'h00;
        dbin  = 8'h00;
        adhoa = 1'b0;
        dboa  = 1'b0;
        idle();
        m_pch    = 0;
        m_pagex  = 1'b0;
        m_pcwrap = 1'b0;

        // Reset then readback
        #22;
        rst   = 1'b0;
        adhoa = 1'b1;
        #1;
        check("reset_adh", adhout, 8'h00);
        check_all("reset");

        // ADH load with dual drive
        adhin = 8'h3C;
        adhwa = 1'b1;
        step();
        idle();
        dboa = 1'b1;
        #1;
        check("adhload_adh", adhout, 8'h3C);
        check("adhload_db", dbout, 8'h3C);
        adhoa = 1'b0;
        dboa  = 1'b0;
        #1;
        check_all("enables_off");

        // Carry chain from PCL at 0x12FF
        adhoa = 1'b1;
        adhin = 8'h12;
        adhwa = 1'b1;
        step();
        idle();
        m_pcl = 255;
        pclc  = (m_pcl == 255);
        step();
        m_pcl = (m_pcl + 1) % 256;
        idle();
        check("carry_pch", adhout, 8'h13);
        check("carry_pagex", {7'd0, pagex}, 8'h01);
        check_all("carry");
        step();
        check_all("carry_after");

        // Wrap 0xFF -> 0x00
        dbin = 8'hFF;
        dbwa = 1'b1;
        step();
        idle();
        pclc = 1'b1;
        step();
        idle();
        check("wrap_pch", adhout, 8'h00);
        check("wrap_pcwrap", {7'd0, pcwrap}, 8'h01);
        check_all("wrap");
        step();
        check_all("wrap_after");

        // Simultaneous ADH load, DB load and carry
        adhin = 8'h80;
        adhwa = 1'b1;
        dbin  = 8'h40;
        dbwa  = 1'b1;
        pclc  = 1'b1;
        step();
        idle();
        check("simul_pch", adhout, 8'h80);
        check_all("simul");

        // Async reset mid-operation
        adhin = 8'h55;
        adhwa = 1'b1;
        step();
        idle();
        pclc = 1'b1;
        step();
        check_all("pre_rst");
        pclc = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        m_pch    = 0;
        m_pagex  = 1'b0;
        m_pcwrap = 1'b0;
        check("async_rst_pch", adhout, 8'h00);
        check_all("async_rst");
        pclc = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_pch", adhout, 8'h01);
        check_all("post_rst");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            adhin = 8'($urandom);
            dbin  = 8'($urandom);
            adhwa = ($urandom_range(7) == 0);
            dbwa  = ($urandom_range(7) == 0);
            pclc  = ($urandom_range(1) == 1);
            if ($urandom_range(15) == 0) begin
                adhin = 8'hFF;
                adhwa = 1'b1;
            end
            adhoa = ($urandom_range(3) != 0);
            dboa  = ($urandom_range(1) == 1);
            step();
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
